// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: sequencer state encoding and RV32 major opcodes
// used by both the pipeline controller and the hazard unit.
package pipeline_pkg;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalted  = 2'd2
    } pipe_state_e;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clock) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline sequencer: resolves halt, dmem wait, redirect and load-use stall into
// per-stage enables and registered valid bits, with stall/flush perf counters.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned WAIT_MAX = 255,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hz_stall,
    input  logic             ex_redirect,
    input  logic             me_mem_op,
    input  logic             dmem_ready,
    input  logic             wb_halt,
    output logic             if_en,
    output logic             id_en,
    output logic             ex_en,
    output logic             me_en,
    output logic             wb_en,
    output logic             id_valid,
    output logic             ex_valid,
    output logic             me_valid,
    output logic             wb_valid,
    output logic             pc_redirect,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [CNT_W-1:0] WaitLast = CNT_W'(WAIT_MAX - 1);

    pipe_state_e      state_q, state_d;
    logic             id_valid_q, ex_valid_q, me_valid_q, wb_valid_q;
    logic             id_valid_d, ex_valid_d, me_valid_d, wb_valid_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             timeout_q, timeout_d;

    // Stage inputs only count when the stage actually holds an instruction.
    logic do_halt, do_freeze, do_redirect, do_stall;
    assign do_halt     = wb_valid_q & wb_halt;
    assign do_freeze   = me_valid_q & me_mem_op & ~dmem_ready;
    assign do_redirect = ex_valid_q & ex_redirect;
    assign do_stall    = id_valid_q & hz_stall;

    always_comb begin
        if_en       = 1'b0;
        id_en       = 1'b0;
        ex_en       = 1'b0;
        me_en       = 1'b0;
        wb_en       = 1'b0;
        pc_redirect = 1'b0;
        id_valid_d  = id_valid_q;
        ex_valid_d  = ex_valid_q;
        me_valid_d  = me_valid_q;
        wb_valid_d  = wb_valid_q;
        state_d     = state_q;
        wait_d      = wait_q;
        timeout_d   = timeout_q;

        if (reset || (state_q == StHalted)) begin
            // everything frozen
        end else if (do_halt) begin
            state_d = StHalted;
        end else if (do_freeze) begin
            wb_valid_d = 1'b0;
            state_d    = StMemWait;
            if (wait_q != '1) begin
                wait_d = wait_q + CNT_W'(1);
            end
            if (wait_q >= WaitLast) begin
                timeout_d = 1'b1;
            end
        end else begin
            // A pending wait resolves here and the cycle is decided as a normal RUN cycle.
            state_d    = StRun;
            wait_d     = '0;
            me_valid_d = ex_valid_q;
            wb_valid_d = me_valid_q;
            ex_en      = 1'b1;
            me_en      = 1'b1;
            wb_en      = 1'b1;
            if (do_redirect) begin
                if_en       = 1'b1;
                id_en       = 1'b1;
                pc_redirect = 1'b1;
                id_valid_d  = 1'b0;
                ex_valid_d  = 1'b0;
            end else if (do_stall) begin
                ex_valid_d = 1'b0;
            end else begin
                if_en      = 1'b1;
                id_en      = 1'b1;
                id_valid_d = 1'b1;
                ex_valid_d = id_valid_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StRun;
            id_valid_q <= 1'b0;
            ex_valid_q <= 1'b0;
            me_valid_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wait_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            id_valid_q <= id_valid_d;
            ex_valid_q <= ex_valid_d;
            me_valid_q <= me_valid_d;
            wb_valid_q <= wb_valid_d;
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
        end
    end

    assign id_valid    = id_valid_q;
    assign ex_valid    = ex_valid_q;
    assign me_valid    = me_valid_q;
    assign wb_valid    = wb_valid_q;
    assign halted      = (state_q == StHalted);
    assign mem_timeout = timeout_q;

    logic stall_inc;
    assign stall_inc = ~if_en & ~reset & (state_q != StHalted);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .clr   (reset),
        .inc   (stall_inc),
        .q     (stall_cycles)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clock (clock),
        .clr   (reset),
        .inc   (pc_redirect),
        .q     (flush_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random traffic, checked against a
// model that tracks instruction tags flowing through the ID/EX/ME/WB slots.
module tb_pipeline_ctrl;

    localparam int unsigned WAIT_MAX = 3;
    localparam int unsigned CNT_W    = 4;
    localparam int          CNT_MAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             hz_stall = 1'b0, ex_redirect = 1'b0, me_mem_op = 1'b0;
    logic             dmem_ready = 1'b0, wb_halt = 1'b0;
    logic             if_en, id_en, ex_en, me_en, wb_en;
    logic             id_valid, ex_valid, me_valid, wb_valid;
    logic             pc_redirect, halted, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    pipeline_ctrl #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .hz_stall     (hz_stall),
        .ex_redirect  (ex_redirect),
        .me_mem_op    (me_mem_op),
        .dmem_ready   (dmem_ready),
        .wb_halt      (wb_halt),
        .if_en        (if_en),
        .id_en        (id_en),
        .ex_en        (ex_en),
        .me_en        (me_en),
        .wb_en        (wb_en),
        .id_valid     (id_valid),
        .ex_valid     (ex_valid),
        .me_valid     (me_valid),
        .wb_valid     (wb_valid),
        .pc_redirect  (pc_redirect),
        .halted       (halted),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: each slot holds the tag of the instruction in it, -1 when empty.
    int m_id, m_ex, m_me, m_wb;
    int m_wait, m_stall, m_flush, next_tag;
    bit m_halted, m_tmo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_id = -1; m_ex = -1; m_me = -1; m_wb = -1;
        m_wait = 0; m_stall = 0; m_flush = 0;
        m_halted = 0; m_tmo = 0;
    endtask

    // One clock cycle: drive inputs, compare everything, then advance the model.
    task automatic step(input bit r, input bit hz, input bit rd, input bit mo, input bit dy,
                        input bit ht);
        logic [5:0] exp_en;
        int act;
        reset = r; hz_stall = hz; ex_redirect = rd; me_mem_op = mo; dmem_ready = dy;
        wb_halt = ht;
        #2;
        // 0 frozen, 1 dmem wait, 2 redirect, 3 load-use stall, 4 advance
        if (r || m_halted || (m_wb >= 0 && ht)) act = 0;
        else if (m_me >= 0 && mo && !dy)       act = 1;
        else if (m_ex >= 0 && rd)              act = 2;
        else if (m_id >= 0 && hz)              act = 3;
        else                                   act = 4;
        case (act)
            2:       exp_en = 6'b111111;
            3:       exp_en = 6'b001110;
            4:       exp_en = 6'b111110;
            default: exp_en = 6'b000000;
        endcase
        check("enables_redirect", {26'd0, if_en, id_en, ex_en, me_en, wb_en, pc_redirect},
              {26'd0, exp_en});
        check("valids", {28'd0, id_valid, ex_valid, me_valid, wb_valid},
              {28'd0, m_id >= 0, m_ex >= 0, m_me >= 0, m_wb >= 0});
        check("halted", {31'd0, halted}, {31'd0, m_halted});
        check("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_tmo});
        check("stall_cycles", {28'd0, stall_cycles}, m_stall);
        check("flush_count", {28'd0, flush_count}, m_flush);

        if (!r && !m_halted && !exp_en[5] && m_stall < CNT_MAX) m_stall++;
        if (r) begin
            model_clear();
        end else if (!m_halted) begin
            if (m_wb >= 0 && ht) begin
                m_halted = 1;
            end else if (act == 1) begin
                m_wb = -1;
                m_wait++;
                if (m_wait >= WAIT_MAX) m_tmo = 1;
            end else begin
                m_wait = 0;
                m_wb = m_me;
                m_me = m_ex;
                if (act == 2) begin
                    m_ex = -1;
                    m_id = -1;
                    if (m_flush < CNT_MAX) m_flush++;
                end else if (act == 3) begin
                    m_ex = -1;
                end else begin
                    m_ex = m_id;
                    m_id = next_tag++;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        int s0;
        int f0;
        next_tag = 0;
        model_clear();
        @(posedge clock);
        #1;

        // Reset for 3 cycles, then fill the pipe.
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
        check("reset_valids", {28'd0, id_valid, ex_valid, me_valid, wb_valid}, 32'd0);
        check("reset_counters", {24'd0, stall_cycles, flush_count}, 32'd0);
        idle(5);
        check("fill_valids", {28'd0, id_valid, ex_valid, me_valid, wb_valid}, 32'hf);
        check("fill_stall", {28'd0, stall_cycles}, 32'd0);

        // Single load-use stall.
        step(0, 1, 0, 0, 1, 0);
        check("stall_bubble", {30'd0, ex_valid, me_valid}, 32'b01);
        check("stall_count", {28'd0, stall_cycles}, 32'd1);

        // Redirect overrides a simultaneous stall.
        idle(1);
        s0 = stall_cycles;
        step(0, 1, 1, 0, 1, 0);
        check("redirect_kill", {29'd0, id_valid, ex_valid, me_valid}, 32'b001);
        check("redirect_flush", {28'd0, flush_count}, 32'd1);
        check("redirect_no_stall", {28'd0, stall_cycles}, s0);

        // Four-cycle dmem wait; WAIT_MAX=3 also trips the sticky timeout.
        s0 = stall_cycles;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0);
        check("wait_stalls", {28'd0, stall_cycles}, s0 + 4);
        check("wait_wb_bubble", {31'd0, wb_valid}, 32'd0);
        check("wait_timeout", {31'd0, mem_timeout}, 32'd1);
        step(0, 0, 0, 1, 1, 0);
        idle(3);
        check("timeout_sticky", {31'd0, mem_timeout}, 32'd1);

        // Halt from WB, stays halted until reset.
        f0 = flush_count;
        step(0, 0, 0, 0, 1, 1);
        check("halt_set", {31'd0, halted}, 32'd1);
        s0 = stall_cycles;
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 0, 1);
        check("halt_stall_frozen", {28'd0, stall_cycles}, s0);
        check("halt_flush_frozen", {28'd0, flush_count}, f0);
        step(1, 0, 0, 0, 0, 0);
        check("halt_reset", {27'd0, halted, id_valid, ex_valid, me_valid, wb_valid}, 32'd0);
        check("timeout_reset", {31'd0, mem_timeout}, 32'd0);

        // Random traffic, including mid-wait and mid-halt resets.
        for (int i = 0; i < 1500; i++) begin
            bit r;
            r = m_halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 199) == 0);
            step(r, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 0, $urandom_range(0, 4) < 3,
                 $urandom_range(0, 59) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
